bird_motion: RTL
================

Name: bird_motion

Overview:
- Vertical-motion engine for the player sprite.
- Integrates gravity and flap impulses once per video frame and produces the 9-bit `height` (top-row pixel, 0 = screen top, increasing downward).
- Generates `in_game` and consumes `is_dead` from the downstream death detector, which flags `height` < 10 or > 420.
- Also counts frames survived, for scoring.

Parameters:
- START_Y, 200, height loaded on game start.
- GRAVITY, 1, velocity increment per frame (pixels/frame²).
- FLAP_V, 8, upward speed set by a flap (velocity becomes −FLAP_V).
- MAX_FALL, 10, terminal downward velocity (pixels/frame).
- Y_MAX, 479, maximum height value (bottom screen row).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- frame_tick  input  1  single-cycle pulse, once per frame
- flap  input  1  debounced flap button, level
- start  input  1  single-cycle start/restart request
- is_dead  input  1  from death detector; 1 = dead
- height  output  9  sprite top row, unsigned
- velocity  output  8  signed pixels/frame, positive = downward
- in_game  output  1  1 while state is PLAY
- frames_alive  output  16  frame_ticks survived in current/last game

Behaviour:
- Reset (async, active-high):
  - state=IDLE, height=START_Y, velocity=0, in_game=0, frames_alive=0.
  - flap_prev=0, flap_pend=0.
- All outputs are registered.
- Flap capture:
  - flap_prev samples `flap` every cycle.
  - A rising edge (flap & ~flap_prev) sets flap_pend, but only in PLAY.
  - flap_pend clears on the frame_tick that consumes it.
  - An edge on the same cycle as frame_tick counts for that tick.
  - Multiple edges between ticks count as one.
- IDLE:
  - height=START_Y, velocity=0, flap_pend held 0.
  - `start`=1 → PLAY next cycle, with in_game=1 and frames_alive=0.
- PLAY, death check:
  - If is_dead=1 on any cycle → OVER next cycle; no kinematic update that cycle, even if frame_tick=1.
  - is_dead is sampled starting from the first cycle of PLAY; in_game is registered, so the detector output is already valid.
- PLAY, frame update (on frame_tick with is_dead=0):
  - Velocity: if flap_pend, v_new=−FLAP_V; otherwise v_new=min(velocity+GRAVITY, MAX_FALL), computed in signed 9-bit.
  - Height: h_new=height+v_new, computed in signed 11-bit and clamped to [0, Y_MAX].
  - height←h_new and velocity←v_new in the same cycle, so latency is 1 clk from frame_tick.
  - frames_alive increments, saturating at 65535.
- PLAY, other events:
  - Cycles without frame_tick: height and velocity hold.
  - `start` is ignored.
- OVER:
  - in_game=0; height, velocity and frames_alive frozen; flap ignored and flap_pend cleared.
  - `start`=1 → PLAY with height=START_Y, velocity=0, frames_alive=0, in_game=1.
- Reset asserted mid-game: immediate return to the reset values, regardless of state or pending flap.

Test Plan:
- Reset, start, no flap, is_dead from a bench model of the detector:
  - heights after ticks 1..5 are 201, 203, 206, 210, 215;
  - velocity saturates at 10 on tick 10 (height 255);
  - tick 26 → 415, tick 27 → 425;
  - OVER one cycle after is_dead, in_game=0, frames_alive=27.
- Start, flap edge 3 cycles before tick 1 → velocity=−8, height=192. Tick 2 without flap → velocity=−7, height=185.
- Flap held high across 5 ticks → only one impulse: heights 192, 185, 179, 174, 170.
- Flap edge coincident with frame_tick → applied on that tick. Second edge in the same frame interval → no extra effect.
- is_dead forced 0, a flap every frame for 30 ticks → height clamps at 0 from tick 25 onward, never wraps. The downward mirror case clamps at 479.
- Extra cases:
  - start during PLAY → ignored;
  - start in OVER → height=200, frames_alive=0;
  - reset pulse mid-PLAY → outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/bird_motion.sv
// rtl/bird_motion.sv - vertical-motion engine for the player sprite
// Integrates gravity and flap impulses per frame, tracks game state and frames survived.
module bird_motion #(
  parameter int START_Y  = 200,
  parameter int GRAVITY  = 1,
  parameter int FLAP_V   = 8,
  parameter int MAX_FALL = 10,
  parameter int Y_MAX    = 479
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        flap,
  input  logic        start,
  input  logic        is_dead,
  output logic [8:0]  height,
  output logic [7:0]  velocity,
  output logic        in_game,
  output logic [15:0] frames_alive
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [8:0]         START_H = 9'(START_Y);
  localparam logic signed [8:0]  GRAV_S  = 9'(GRAVITY);
  localparam logic signed [8:0]  MAXF_S  = 9'(MAX_FALL);
  localparam logic signed [8:0]  FLAP_S  = -9'(FLAP_V);
  localparam logic signed [10:0] YMAX_S  = 11'(Y_MAX);

  state_t state, state_nxt;
  logic        flap_prev, flap_pend, pend_nxt;
  logic [8:0]  height_nxt;
  logic [7:0]  velocity_nxt;
  logic        in_game_nxt;
  logic [15:0] frames_nxt;

  logic               flap_edge, flap_hit;
  logic signed [8:0]  v_grav, v_new;
  logic signed [10:0] h_sum;
  logic [8:0]         h_clamp;

  assign flap_edge = flap & ~flap_prev;
  // An edge arriving with the tick itself still counts for that tick.
  assign flap_hit  = flap_pend | flap_edge;

  always_comb begin
    v_grav = $signed({velocity[7], velocity}) + GRAV_S;
    if (flap_hit)
      v_new = FLAP_S;
    else if (v_grav > MAXF_S)
      v_new = MAXF_S;
    else
      v_new = v_grav;
    h_sum = $signed({2'b00, height}) + $signed({{2{v_new[8]}}, v_new});
    if (h_sum < 11'sd0)
      h_clamp = 9'd0;
    else if (h_sum > YMAX_S)
      h_clamp = YMAX_S[8:0];
    else
      h_clamp = h_sum[8:0];
  end

  always_comb begin
    state_nxt    = state;
    height_nxt   = height;
    velocity_nxt = velocity;
    in_game_nxt  = in_game;
    frames_nxt   = frames_alive;
    pend_nxt     = flap_pend;
    case (state)
      IDLE: begin
        height_nxt   = START_H;
        velocity_nxt = 8'd0;
        pend_nxt     = 1'b0;
        if (start) begin
          state_nxt   = PLAY;
          in_game_nxt = 1'b1;
          frames_nxt  = 16'd0;
        end
      end
      PLAY: begin
        // Death wins over a coincident tick: the sprite freezes where it died.
        if (is_dead) begin
          state_nxt   = OVER;
          in_game_nxt = 1'b0;
          pend_nxt    = 1'b0;
        end else if (frame_tick) begin
          height_nxt   = h_clamp;
          velocity_nxt = v_new[7:0];
          pend_nxt     = 1'b0;
          if (frames_alive != 16'hFFFF)
            frames_nxt = frames_alive + 16'd1;
        end else if (flap_edge) begin
          pend_nxt = 1'b1;
        end
      end
      OVER: begin
        pend_nxt    = 1'b0;
        in_game_nxt = 1'b0;
        if (start) begin
          state_nxt    = PLAY;
          height_nxt   = START_H;
          velocity_nxt = 8'd0;
          frames_nxt   = 16'd0;
          in_game_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        in_game_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      height       <= START_H;
      velocity     <= 8'd0;
      in_game      <= 1'b0;
      frames_alive <= 16'd0;
      flap_prev    <= 1'b0;
      flap_pend    <= 1'b0;
    end else begin
      state        <= state_nxt;
      height       <= height_nxt;
      velocity     <= velocity_nxt;
      in_game      <= in_game_nxt;
      frames_alive <= frames_nxt;
      flap_prev    <= flap;
      flap_pend    <= pend_nxt;
    end
  end

endmodule
